// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// sar_pkg -- shared state encoding and parameter limits for the SAR sequencer
// Revision: 1.0
// ============================================================================
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    WAIT_EOC = 2'd2
  } seq_state_t;

  localparam int DATA_W_DEF   = 10;
  localparam int AVG_LOG2_MIN = 0;
  localparam int AVG_LOG2_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/sar_avg_acc.sv
`default_nettype none
// ============================================================================
// sar_avg_acc -- sums 2^AVG_LOG2 SAR codes and emits the truncated mean
// Revision: 1.0
// ============================================================================
module sar_avg_acc
  import sar_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1 << AVG_LOG2);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Sum of at most 2^AVG_LOG2 codes always fits in DATA_W+AVG_LOG2 bits.
  assign sum     = acc + ACC_W'(sample);
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        if (cnt_inc == N_SAMPLES) begin
          acc    <= '0;
          cnt    <= '0;
          result <= DATA_W'(sum >> AVG_LOG2);
          done   <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt_inc;
        end
      end else if (clear) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sar_conv_sequencer.sv
`default_nettype none
// ============================================================================
// sar_conv_sequencer -- periodic cnvst, eoc capture, averaging, valid/ready out
// Optional feature macro: SAR_SEQ_TIMEOUT_EN (eoc watchdog).  Revision: 1.0
// ============================================================================
module sar_conv_sequencer
  import sar_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PERIOD   = 40,
  parameter int CNVST_W  = 2,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              cnvst,
  input  logic [DATA_W-1:0] sar,
  input  logic              eoc,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int PCNT_W = $clog2(PERIOD);
  localparam int SCNT_W = $clog2(CNVST_W + 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX  = PCNT_W'(PERIOD - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(CNVST_W - 1);

  if (CNVST_W < 1 || PERIOD < CNVST_W + 2 || TIMEOUT < 1 ||
      AVG_LOG2 < AVG_LOG2_MIN || AVG_LOG2 > AVG_LOG2_MAX) begin : g_param_check
    $error("sar_conv_sequencer: illegal parameter set");
  end

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [PCNT_W-1:0] pcnt;
  logic [SCNT_W-1:0] scnt;
  logic              eoc_q;
  logic              eoc_rise;
  logic              acc_clear;
  logic              tmo_expired;
  logic [DATA_W-1:0] res;
  logic              res_done;

  assign eoc_rise = (state == WAIT_EOC) && eoc && !eoc_q;

  always_comb begin
    state_nxt = state;
    acc_clear = 1'b0;
    case (state)
      IDLE: begin
        if (en && pcnt == PCNT_MAX) state_nxt = START;
        else if (!en)               acc_clear = 1'b1;
      end
      START: begin
        if (scnt == SCNT_LAST) state_nxt = WAIT_EOC;
      end
      WAIT_EOC: begin
        if (eoc_rise || tmo_expired) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Period counter restarts on START entry; reset value lets the first start go at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnvst <= 1'b0;
      pcnt  <= PCNT_MAX;
      scnt  <= '0;
      eoc_q <= 1'b0;
    end else begin
      cnvst <= (state_nxt == START);
      eoc_q <= eoc;
      scnt  <= (state == START) ? scnt + 1'b1 : '0;
      if (state_nxt == START && state != START) pcnt <= '0;
      else if (pcnt != PCNT_MAX)                pcnt <= pcnt + 1'b1;
    end
  end

  sar_avg_acc #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk     (clk),
    .rst     (rst),
    .clear   (acc_clear),
    .capture (eoc_rise),
    .sample  (sar),
    .result  (res),
    .done    (res_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (res_done) begin
      if (!dout_valid || dout_ready) begin
        dout       <= res;
        dout_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

`ifdef SAR_SEQ_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  logic [TCNT_W-1:0] tcnt;
  logic              timeout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt <= (state == WAIT_EOC) ? tcnt + 1'b1 : '0;
      if (tmo_expired && !eoc_rise) timeout_q <= 1'b1;
    end
  end

  assign tmo_expired = (state == WAIT_EOC) && (tcnt == TCNT_LAST);
  assign timeout_err = timeout_q;
`else
  assign tmo_expired = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sar_conv_sequencer.sv
`default_nettype none
// tb_sar_conv_sequencer -- randomized bench; expectations come from a
// transaction-level averaging model and the cnvst spacing rule max(PERIOD, L+3).
module tb_sar_conv_sequencer;

  localparam int DATA_W   = 10;
  localparam int PERIOD   = 40;
  localparam int CNVST_W  = 2;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 64;
  localparam int NAVG     = 1 << AVG_LOG2;

  logic              clk = 1'b0;
  logic              rst, en, eoc, dout_ready;
  logic              cnvst, dout_valid, overrun, timeout_err;
  logic [DATA_W-1:0] sar, dout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int samples[$];
  bit exp_valid, exp_overrun, have_prev;
  int exp_dout, prev_lat, rise_cyc, prev_rise_cyc;

  always #5 clk = ~clk;

  sar_conv_sequencer #(
    .DATA_W   (DATA_W),
    .PERIOD   (PERIOD),
    .CNVST_W  (CNVST_W),
    .AVG_LOG2 (AVG_LOG2),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cnvst       (cnvst),
    .sar         (sar),
    .eoc         (eoc),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    samples.delete();
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
    exp_dout    = 0;
    have_prev   = 1'b0;
  endtask

  // Average of every NAVG codes is offered to a one-entry output buffer.
  task automatic model_capture(input int code, output bit offered);
    int sum;
    sum = 0;
    offered = 1'b0;
    samples.push_back(code);
    if (samples.size() == NAVG) begin
      foreach (samples[i]) sum += samples[i];
      samples.delete();
      offered = 1'b1;
      if (!exp_valid || dout_ready) begin
        exp_dout  = sum / NAVG;
        exp_valid = 1'b1;
      end else begin
        exp_overrun = 1'b1;
      end
    end
  endtask

  task automatic wait_rise(input int budget, output int waited);
    waited = 0;
    while (cnvst !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    check("cnvst_rise_seen", cnvst, 1);
  endtask

  // One conversion: eoc is raised 'lat' cycles into WAIT_EOC; en drops at cycle drop_k.
  task automatic run_conv(input int code, input int lat, input int drop_k);
    int waited, k, exp_gap;
    bit offered;
    wait_rise(200, waited);
    rise_cyc = cyc;
    if (have_prev) begin
      exp_gap = (prev_lat + 3 > PERIOD) ? prev_lat + 3 : PERIOD;
      check("cnvst_spacing", rise_cyc - prev_rise_cyc, exp_gap);
    end
    tick(); check("cnvst_high", cnvst, 1);
    tick(); check("cnvst_low", cnvst, 0);
    k = 2;
    while (k < lat + 1) begin
      if (k == drop_k) en = 1'b0;
      tick();
      k++;
    end
    sar = DATA_W'(code);
    eoc = 1'b1;
    tick();
    tick();
    model_capture(code, offered);
    check("dout_valid", dout_valid, exp_valid);
    check("dout", dout, exp_dout);
    check("overrun", overrun, exp_overrun);
    eoc = 1'b0;
    sar = DATA_W'($urandom);
    if (exp_valid && dout_ready) exp_valid = 1'b0;
    prev_rise_cyc = rise_cyc;
    prev_lat      = lat;
    have_prev     = 1'b1;
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_cnvst"},       cnvst,       0);
    check({phase, "_dout"},        dout,        0);
    check({phase, "_dout_valid"},  dout_valid,  0);
    check({phase, "_overrun"},     overrun,     0);
    check({phase, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bit saw;
    rst = 1'b0; en = 1'b0; eoc = 1'b0; sar = '0; dout_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs("reset");

    // Release with en=1: first start at the very next edge.
    rst = 1'b1; en = 1'b1; dout_ready = 1'b1;
    wait_rise(10, waited);
    check("first_start_latency", waited, 1);

    // Directed group 100,101,102,104 -> 101; the 50-cycle conversion checks the 53 spacing.
    run_conv(100, 20, -1);
    run_conv(101, 50, -1);
    run_conv(102, 7, -1);
    run_conv(104, 33, -1);

    for (int i = 0; i < 12; i++)
      run_conv($urandom_range(0, 1023), (i == 11) ? $urandom_range(1, 30) : $urandom_range(1, 60), -1);

    // Two results with dout_ready low: the second is dropped.
    tick();
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      run_conv($urandom_range(0, 1023), $urandom_range(1, 30), -1);
    dout_ready = 1'b1;
    tick();
    check("valid_drop_on_ready", dout_valid, 0);
    exp_valid = 1'b0;

    // Partial group, then en low in IDLE clears it; stray eoc outside WAIT_EOC ignored.
    run_conv($urandom_range(0, 1023), $urandom_range(1, 30), -1);
    run_conv($urandom_range(0, 1023), $urandom_range(1, 30), -1);
    en = 1'b0;
    samples.delete();
    sar = DATA_W'($urandom_range(0, 1023));
    eoc = 1'b1;
    tick(); tick();
    eoc = 1'b0;
    saw = 1'b0;
    repeat (60) begin
      tick();
      if (cnvst !== 1'b0 || dout_valid !== 1'b0) saw = 1'b1;
    end
    check("idle_quiet", saw, 0);

    // Re-enable; en dropped 5 cycles into the 4th conversion, its result still arrives.
    en = 1'b1;
    have_prev = 1'b0;
    for (int i = 0; i < 3; i++)
      run_conv($urandom_range(0, 1023), $urandom_range(1, 60), -1);
    run_conv($urandom_range(0, 1023), 25, 5);
    saw = 1'b0;
    repeat (120) begin
      tick();
      if (cnvst !== 1'b0) saw = 1'b1;
    end
    check("no_start_after_en_drop", saw, 0);

    // Reset in the middle of WAIT_EOC.
    en = 1'b1;
    have_prev = 1'b0;
    wait_rise(100, waited);
    repeat (8) tick();
    check("overrun_sticky", overrun, exp_overrun);
    rst = 1'b0;
    tick();
    check_reset_outputs("midconv_reset");
    model_reset();
    tick();

    // SAR never answers.
    rst = 1'b1;
    wait_rise(10, waited);
    check("restart_latency", waited, 1);
    repeat (65) tick();
    check("timeout_err_before", timeout_err, 0);
    tick();
`ifdef SAR_SEQ_TIMEOUT_EN
    check("timeout_err_set", timeout_err, 1);
    check("cnvst_idle_after_timeout", cnvst, 0);
    tick();
    check("cnvst_after_timeout", cnvst, 1);
`else
    saw = 1'b0;
    repeat (150) begin
      tick();
      if (cnvst !== 1'b0) saw = 1'b1;
    end
    check("no_start_without_timeout", saw, 0);
    check("timeout_err_tied", timeout_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
